// File: rtl/reg_scoreboard_if.sv
// Decode/writeback bundle between the pipeline and the register scoreboard.
interface reg_scoreboard_if #(
   parameter int NREGS = 32,
   parameter int CW    = 3
);
   logic             ValidD;
   logic             FlushD;
   logic [4:0]       Rs1D;
   logic [4:0]       Rs2D;
   logic             UseRs1D;
   logic             UseRs2D;
   logic [4:0]       RdD;
   logic             RegWriteD;
   logic             LongD;
   logic             WbValidW;
   logic [4:0]       WbRdW;
   logic             StallD;
   logic             IssueD;
   logic [NREGS-1:0] PendingOut;
   logic [CW-1:0]    OutCount;
   logic             SbError;

   // Pipeline side: drives decode/writeback info, observes stall and state.
   modport master (
      output ValidD, FlushD, Rs1D, Rs2D, UseRs1D, UseRs2D, RdD, RegWriteD,
             LongD, WbValidW, WbRdW,
      input  StallD, IssueD, PendingOut, OutCount, SbError
   );

   // Scoreboard side.
   modport slave (
      input  ValidD, FlushD, Rs1D, Rs2D, UseRs1D, UseRs2D, RdD, RegWriteD,
             LongD, WbValidW, WbRdW,
      output StallD, IssueD, PendingOut, OutCount, SbError
   );
endinterface

// File: rtl/reg_scoreboard.sv
// Decode-stage scoreboard for long-latency destinations (loads, mul/div).
// Stalls decode on RAW/WAW against results not yet produced, and when the
// outstanding-write budget is exhausted. A writeback in W resolves the
// hazard in the same cycle since its value is forwarded.
module reg_scoreboard #(
   parameter int NREGS   = 32,
   parameter int MAX_OUT = 4,
   parameter int CW      = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   reg_scoreboard_if.slave  sb
);

   logic [NREGS-1:0] pend_q, pend_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             err_q, err_d;

   logic [NREGS-1:0] eff;
   logic             raw, waw, full;
   logic             wb_clears;
   logic             stall, issue;
   logic             set, clr;

   // Hazard detection, issue decision and next-state computation.
   always_comb begin
      eff = pend_q;
      if (sb.WbValidW) eff[sb.WbRdW] = 1'b0;

      wb_clears = sb.WbValidW & pend_q[sb.WbRdW];

      raw = sb.ValidD &
            ((sb.UseRs1D & (sb.Rs1D != 5'd0) & eff[sb.Rs1D]) |
             (sb.UseRs2D & (sb.Rs2D != 5'd0) & eff[sb.Rs2D]));
      waw = sb.ValidD & sb.RegWriteD & (sb.RdD != 5'd0) & eff[sb.RdD];
      full = sb.ValidD & sb.RegWriteD & sb.LongD & (sb.RdD != 5'd0) &
             (cnt_q == CW'(MAX_OUT)) & ~wb_clears;

      stall = ~sb.FlushD & (raw | waw | full);
      issue = sb.ValidD & ~sb.FlushD & ~stall;

      set = issue & sb.RegWriteD & sb.LongD & (sb.RdD != 5'd0);
      clr = sb.WbValidW & (sb.WbRdW != 5'd0) & pend_q[sb.WbRdW];

      // Clear applied before set so a same-register collision keeps the bit.
      pend_d = pend_q;
      if (clr) pend_d[sb.WbRdW] = 1'b0;
      if (set) pend_d[sb.RdD]   = 1'b1;

      cnt_d = cnt_q;
      if (set && !clr)      cnt_d = cnt_q + 1'b1;
      else if (clr && !set) cnt_d = cnt_q - 1'b1;

      err_d = err_q;
      if (sb.WbValidW && ((sb.WbRdW == 5'd0) || !pend_q[sb.WbRdW])) err_d = 1'b1;
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

   assign sb.StallD     = stall;
   assign sb.IssueD     = issue;
   assign sb.PendingOut = pend_q;
   assign sb.OutCount   = cnt_q;
   assign sb.SbError    = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard with hand-computed expectations.
module tb_reg_scoreboard;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   reg_scoreboard_if #(.NREGS(32), .CW(3)) sbif ();

   reg_scoreboard #(.NREGS(32), .MAX_OUT(4), .CW(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sb    (sbif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle();
      sbif.ValidD    = 1'b0;
      sbif.FlushD    = 1'b0;
      sbif.Rs1D      = 5'd0;
      sbif.Rs2D      = 5'd0;
      sbif.UseRs1D   = 1'b0;
      sbif.UseRs2D   = 1'b0;
      sbif.RdD       = 5'd0;
      sbif.RegWriteD = 1'b0;
      sbif.LongD     = 1'b0;
      sbif.WbValidW  = 1'b0;
      sbif.WbRdW     = 5'd0;
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic long_op(input logic [4:0] rd);
      idle();
      sbif.ValidD    = 1'b1;
      sbif.RegWriteD = 1'b1;
      sbif.LongD     = 1'b1;
      sbif.RdD       = rd;
   endtask

   task automatic wb(input logic [4:0] rd);
      idle();
      sbif.WbValidW = 1'b1;
      sbif.WbRdW    = rd;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      idle();
      rst_n = 1'b0;

      // Reset held two cycles while a long op is requested.
      long_op(5'd5);
      tick();
      tick();
      check("rst_pending", sbif.PendingOut, 32'h0);
      check("rst_count",   32'(sbif.OutCount), 32'd0);
      check("rst_err",     32'(sbif.SbError), 32'd0);
      rst_n = 1'b1;
      idle();
      tick();

      // Basic RAW with same-cycle writeback bypass.
      long_op(5'd5);
      #1 check("raw_issue0", 32'(sbif.IssueD), 32'd1);
      tick();
      check("raw_pend5", sbif.PendingOut, 32'h0000_0020);
      check("raw_cnt1",  32'(sbif.OutCount), 32'd1);
      idle();
      sbif.ValidD  = 1'b1;
      sbif.Rs1D    = 5'd5;
      sbif.UseRs1D = 1'b1;
      #1 check("raw_stall", 32'(sbif.StallD), 32'd1);
      check("raw_noissue", 32'(sbif.IssueD), 32'd0);
      tick();
      check("raw_stall_c2", 32'(sbif.StallD), 32'd1);
      tick();
      sbif.WbValidW = 1'b1;
      sbif.WbRdW    = 5'd5;
      #1 check("raw_bypass_stall", 32'(sbif.StallD), 32'd0);
      check("raw_bypass_issue", 32'(sbif.IssueD), 32'd1);
      tick();
      check("raw_clr_pend", sbif.PendingOut, 32'h0);
      check("raw_clr_cnt",  32'(sbif.OutCount), 32'd0);
      check("raw_no_err",   32'(sbif.SbError), 32'd0);

      // WAW and x0 destination.
      long_op(5'd7);
      tick();
      idle();
      sbif.ValidD    = 1'b1;
      sbif.RegWriteD = 1'b1;
      sbif.RdD       = 5'd7;
      #1 check("waw_stall", 32'(sbif.StallD), 32'd1);
      long_op(5'd0);
      #1 check("x0_issue", 32'(sbif.IssueD), 32'd1);
      tick();
      check("x0_pend", sbif.PendingOut, 32'h0000_0080);
      check("x0_cnt",  32'(sbif.OutCount), 32'd1);
      // ValidD low never stalls even with a pending source.
      idle();
      sbif.Rs1D    = 5'd7;
      sbif.UseRs1D = 1'b1;
      #1 check("novalid_stall", 32'(sbif.StallD), 32'd0);
      wb(5'd7);
      tick();
      check("waw_clr_cnt", 32'(sbif.OutCount), 32'd0);

      // Outstanding budget full.
      for (int unsigned r = 1; r <= 4; r++) begin
         long_op(5'(r));
         tick();
      end
      check("full_cnt",  32'(sbif.OutCount), 32'd4);
      check("full_pend", sbif.PendingOut, 32'h0000_001E);
      long_op(5'd9);
      #1 check("full_stall", 32'(sbif.StallD), 32'd1);
      sbif.WbValidW = 1'b1;
      sbif.WbRdW    = 5'd1;
      #1 check("full_wb_issue", 32'(sbif.IssueD), 32'd1);
      tick();
      check("full_wb_cnt",  32'(sbif.OutCount), 32'd4);
      check("full_wb_pend", sbif.PendingOut, 32'h0000_021C);
      wb(5'd2); tick();
      wb(5'd3); tick();
      wb(5'd4); tick();
      wb(5'd9); tick();
      check("drain_cnt",  32'(sbif.OutCount), 32'd0);
      check("drain_pend", sbif.PendingOut, 32'h0);

      // Set/clear collision on the same register.
      long_op(5'd6);
      tick();
      long_op(5'd6);
      sbif.WbValidW = 1'b1;
      sbif.WbRdW    = 5'd6;
      #1 check("coll_issue", 32'(sbif.IssueD), 32'd1);
      tick();
      check("coll_pend", sbif.PendingOut, 32'h0000_0040);
      check("coll_cnt",  32'(sbif.OutCount), 32'd1);
      wb(5'd6);
      tick();
      check("coll_drain", 32'(sbif.OutCount), 32'd0);

      // Flush suppresses stall and issue.
      long_op(5'd8);
      tick();
      long_op(5'd10);
      sbif.FlushD  = 1'b1;
      sbif.Rs1D    = 5'd8;
      sbif.UseRs1D = 1'b1;
      #1 check("flush_stall", 32'(sbif.StallD), 32'd0);
      check("flush_issue", 32'(sbif.IssueD), 32'd0);
      tick();
      check("flush_pend", sbif.PendingOut, 32'h0000_0100);
      check("flush_cnt",  32'(sbif.OutCount), 32'd1);

      // Writeback to a non-pending register is a sticky error.
      wb(5'd12);
      tick();
      check("err_set",  32'(sbif.SbError), 32'd1);
      check("err_pend", sbif.PendingOut, 32'h0000_0100);
      check("err_cnt",  32'(sbif.OutCount), 32'd1);
      idle();
      tick();
      check("err_sticky", 32'(sbif.SbError), 32'd1);

      // Reset with three outstanding, while issue and writeback are active.
      long_op(5'd10); tick();
      long_op(5'd11); tick();
      check("pre_rst_cnt", 32'(sbif.OutCount), 32'd3);
      long_op(5'd13);
      sbif.WbValidW = 1'b1;
      sbif.WbRdW    = 5'd8;
      rst_n = 1'b0;
      tick();
      check("midrst_pend", sbif.PendingOut, 32'h0);
      check("midrst_cnt",  32'(sbif.OutCount), 32'd0);
      check("midrst_err",  32'(sbif.SbError), 32'd0);
      rst_n = 1'b1;
      idle();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Tracks destination registers of long-latency instructions (loads, mul/div) that are issued but not yet written back.
- Sits in the decode stage as the producer-side counterpart to the forwarding unit. Forwarding resolves hazards against results already in M/W; this block stalls decode on RAW/WAW hazards against results that do not exist yet.
- Clears entries when the long-latency writeback completes in W.

Parameters:
- NREGS, 32, number of architectural registers. Register 0 is hardwired zero.
- MAX_OUT, 4, maximum simultaneously outstanding long-latency writes.
- CW, 3, width of the outstanding counter. Must satisfy 2^CW > MAX_OUT.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- ValidD  in  1  decode holds a valid instruction requesting issue.
- FlushD  in  1  decode instruction is squashed. It is never issued and never stalls.
- Rs1D  in  5  source register 1.
- Rs2D  in  5  source register 2.
- UseRs1D  in  1  instruction reads Rs1D.
- UseRs2D  in  1  instruction reads Rs2D.
- RdD  in  5  destination register.
- RegWriteD  in  1  instruction writes RdD.
- LongD  in  1  instruction is long-latency.
- WbValidW  in  1  a long-latency result is written back this cycle.
- WbRdW  in  5  destination of that writeback.
- StallD  out  1  combinational. Decode must hold.
- IssueD  out  1  combinational. Equals ValidD & ~FlushD & ~StallD.
- PendingOut  out  NREGS  pending bitmap, registered.
- OutCount  out  CW  outstanding count, registered.
- SbError  out  1  sticky protocol-error flag, registered.

Behaviour:
- Reset: when rst_n=0 at a rising edge, pending, OutCount and SbError are all cleared to 0. Reset takes priority over any issue or writeback in that cycle, including mid-operation; all in-flight entries are discarded.
- Effective pending (combinational): eff[r] = pending[r] & ~(WbValidW & WbRdW==r). A writeback in the same cycle resolves the hazard, because its value is forwarded from W.
- raw = ValidD & ((UseRs1D & Rs1D!=0 & eff[Rs1D]) | (UseRs2D & Rs2D!=0 & eff[Rs2D])).
- waw = ValidD & RegWriteD & RdD!=0 & eff[RdD].
- full = ValidD & RegWriteD & LongD & RdD!=0 & (OutCount==MAX_OUT) & ~WbValidW_clears. Here WbValidW_clears = WbValidW & pending[WbRdW].
- StallD = ~FlushD & (raw | waw | full). StallD is 0 whenever ValidD=0 or FlushD=1.
- set = IssueD & RegWriteD & LongD & RdD!=0. On set, pending[RdD] <= 1 at the next edge.
- clr = WbValidW & WbRdW!=0 & pending[WbRdW]. On clr, pending[WbRdW] <= 0 at the next edge.
- Simultaneous set and clr to the same register: set wins and the bit stays 1. OutCount is unchanged.
- OutCount next value is OutCount + set - clr. It never exceeds MAX_OUT and never underflows.
- Latency: an issued long-op's destination is visible in PendingOut one cycle after IssueD. It stalls a dependent instruction in decode from that cycle onward.
- Error: WbValidW with WbRdW==0, or with pending[WbRdW]==0, sets SbError <= 1 at the next edge. SbError stays 1 until reset. An erroneous writeback changes no other state.
- Short (LongD=0) writers never set pending. Their hazards are covered by forwarding and load-use logic elsewhere.
- RdD==0 and Rs*D==0 never cause stalls and never set pending.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with ValidD=1, LongD=1, RdD=5 -> PendingOut=0, OutCount=0, SbError=0, no bit set.
- Basic RAW: issue long op RdD=5 in cycle 0. In cycle 1 present Rs1D=5, UseRs1D=1 -> StallD=1, IssueD=0. Then WbValidW=1, WbRdW=5 in cycle 3 -> StallD=0 in cycle 3 (same-cycle bypass), PendingOut[5]=0 in cycle 4.
- WAW and x0: pending[7]=1, present RdD=7, RegWriteD=1 -> StallD=1. Issue long op with RdD=0 -> IssueD=1, PendingOut unchanged, OutCount unchanged.
- Full: issue long ops to x1..x4 -> OutCount=4. A 5th long op to x9 gives StallD=1. The same op with WbValidW=1, WbRdW=1 gives IssueD=1, and next cycle OutCount=4 and PendingOut has bits {2,3,4,9}.
- Set/clear collision: pending[6]=1. WbValidW with WbRdW=6 and a long op issuing RdD=6 in the same cycle -> IssueD=1, next cycle PendingOut[6]=1, OutCount unchanged.
- Flush/error/reset mid-op: FlushD=1 with a RAW hazard -> StallD=0, IssueD=0, no set. WbValidW with WbRdW=12 not pending -> SbError=1 and stays 1. Assert rst_n=0 with 3 outstanding -> all state is 0 next cycle.
